prach_sc_extract: RTL



---
 rtl/prach_sc_extract.sv | 118 +++++++++++
 1 files changed

// File: rtl/prach_sc_extract.sv
// prach_sc_extract: pick NUM_SC PRACH bins from natural-order FFT output, buffering bins past DC for in-order replay; `define PRACH_SC_EXTRACT_ERRCNT_EN adds err_cnt
module prach_sc_extract #(
    parameter int NUM_FFT_POINTS = 1536,
    parameter int NUM_SC         = 839,
    parameter int START_BIN      = 1117,
    parameter int BUF_DEPTH      = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din_dr,
    input  logic [15:0] din_di,
    input  logic        din_dv,
    input  logic        sync_in,
    output logic [15:0] dout_dr,
    output logic [15:0] dout_di,
    output logic        dout_dv,
    output logic        sync_out,
    output logic        err
`ifdef PRACH_SC_EXTRACT_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);
    localparam int WRAP_LEN = (START_BIN + NUM_SC > NUM_FFT_POINTS) ? START_BIN + NUM_SC - NUM_FFT_POINTS : 0;
    localparam int DIR_END  = (START_BIN + NUM_SC < NUM_FFT_POINTS) ? START_BIN + NUM_SC : NUM_FFT_POINTS;
    localparam int BW       = $clog2(NUM_FFT_POINTS);
    localparam int AW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    if (BUF_DEPTH < WRAP_LEN) begin : g_depth_chk
        $error("prach_sc_extract: BUF_DEPTH smaller than wrap length");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   bin_cnt, idx;
    logic [AW-1:0]   rd_cnt;
    logic            sync_hit, accept, wr_en, rd_en, direct, last_bin, last_rd, err_nxt;
    logic [31:0]     ram [BUF_DEPTH];
    logic [31:0]     ram_q, s1_data;
    logic            s1_v, s1_sync, rd_v;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: a sync always (re)starts collection; last bin ends it; drain ends on its final read
    always_comb begin
        state_nxt = (state == IDLE)    ? (sync_hit ? COLLECT : IDLE) :
                    (state == COLLECT) ? (last_bin ? ((WRAP_LEN > 0) ? DRAIN : IDLE) : COLLECT) :
                    (state == DRAIN)   ? (sync_hit ? COLLECT : (last_rd ? IDLE : DRAIN)) : IDLE;
    end

    // control decode: a sync bin is bin 0 wherever it arrives; the final read still issues alongside a new sync
    always_comb begin
        sync_hit = din_dv & sync_in;
        last_rd  = (state == DRAIN) & (int'(rd_cnt) == WRAP_LEN - 1);
        accept   = (state == COLLECT) ? din_dv : sync_hit;
        idx      = sync_hit ? '0 : bin_cnt;
        wr_en    = accept & (int'(idx) < WRAP_LEN);
        direct   = accept & (int'(idx) >= START_BIN) & (int'(idx) < DIR_END);
        last_bin = accept & (int'(idx) == NUM_FFT_POINTS - 1);
        rd_en    = (state == DRAIN) & (~sync_hit | last_rd);
        err_nxt  = (state == COLLECT) ? (sync_hit & (bin_cnt != '0)) :
                   (state == DRAIN) & din_dv & ~(sync_hit & last_rd);
    end

    // bin and drain-read counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt <= '0;
            rd_cnt  <= '0;
        end else begin
            if (accept) bin_cnt <= idx + 1'b1;
            rd_cnt <= rd_en ? rd_cnt + 1'b1 : '0;
        end
    end

    // wrap buffer, imag in the upper half
    always_ff @(posedge clk) begin
        if (wr_en) ram[AW'(idx)] <= {din_di, din_dr};
        if (rd_en) ram_q <= ram[rd_cnt];
    end

    // direct-path stage aligned with the RAM read stage, then a shared output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_sync  <= 1'b0;
            s1_data  <= '0;
            rd_v     <= 1'b0;
            dout_dv  <= 1'b0;
            sync_out <= 1'b0;
            dout_dr  <= '0;
            dout_di  <= '0;
            err      <= 1'b0;
        end else begin
            s1_v     <= direct;
            s1_sync  <= direct & (int'(idx) == START_BIN);
            s1_data  <= {din_di, din_dr};
            rd_v     <= rd_en;
            dout_dv  <= s1_v | rd_v;
            sync_out <= s1_v & s1_sync;
            if (s1_v | rd_v) {dout_di, dout_dr} <= rd_v ? ram_q : s1_data;
            err      <= err_nxt;
        end
    end

`ifdef PRACH_SC_EXTRACT_ERRCNT_EN
    // saturating count of protocol errors, in step with the err pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               err_cnt <= '0;
        else if (err_nxt && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
    end
`endif
endmodule
